// File: rtl/axis_pulse_gen.sv
// Step/direction pulse generator for one motion axis: speed handshake,
// counted or continuous moves, graceful disable/abort and a position counter.
module axis_pulse_gen (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        SpeedSet,
  input  logic [7:0]  SpeedCmd,
  input  logic [7:0]  AxisPlsCmd,
  input  logic [15:0] AxisStateCmd,
  input  logic [15:0] RefPos,
  output logic        SpeedSetDone,
  output logic        Pls,
  output logic        Dir,
  output logic        Busy,
  output logic        MoveDone,
  output logic [15:0] CurPos
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        pls_q, pls_d;
  logic        dir_q, dir_d;
  logic        move_done_q, move_done_d;
  logic        speed_done_q, speed_done_d;
  logic [15:0] cur_pos_q, cur_pos_d;
  logic [7:0]  speed_reg_q, speed_reg_d;
  logic [7:0]  remaining_q, remaining_d;
  logic        cont_q, cont_d;
  logic        en_prev_q, en_prev_d;
  logic        en_armed_q, en_armed_d;
  logic [8:0]  div_q, div_d;

  logic        en, dir_cmd, abort, load_pos, stop_req;
  logic        accept, start, phase_end;
  logic [7:0]  eff_speed;
  logic [8:0]  half_period;
  logic [15:0] pos_step;
  logic [7:0]  remaining_dec;
  logic        unused_cmd_bits;

  assign en       = AxisStateCmd[0];
  assign dir_cmd  = AxisStateCmd[1];
  assign abort    = AxisStateCmd[2];
  assign load_pos = AxisStateCmd[3];
  assign unused_cmd_bits = ^AxisStateCmd[15:4];

  always_comb begin
    accept        = SpeedSet && !speed_done_q;
    // A speed accepted this very cycle is already in force for any reload now.
    eff_speed     = accept ? SpeedCmd : speed_reg_q;
    half_period   = 9'd256 - {1'b0, eff_speed};
    phase_end     = (div_q == 9'd1);
    stop_req      = !en || abort;
    pos_step      = dir_q ? (cur_pos_q - 16'd1) : (cur_pos_q + 16'd1);
    remaining_dec = cont_q ? remaining_q : (remaining_q - 8'd1);
    // The arm flag stops an enable held high through reset from looking like a fresh edge.
    start         = en && !en_prev_q && en_armed_q && !abort;

    state_d      = state_q;
    pls_d        = pls_q;
    dir_d        = dir_q;
    move_done_d  = 1'b0;
    speed_done_d = accept;
    cur_pos_d    = cur_pos_q;
    speed_reg_d  = eff_speed;
    remaining_d  = remaining_q;
    cont_d       = cont_q;
    en_prev_d    = en;
    en_armed_d   = en_armed_q || !en;
    div_d        = div_q;

    case (state_q)
      ST_IDLE: begin
        if (load_pos) cur_pos_d = RefPos;
        if (start) begin
          state_d     = ST_RUN;
          pls_d       = 1'b0;
          div_d       = half_period;
          dir_d       = dir_cmd;
          remaining_d = AxisPlsCmd;
          cont_d      = (AxisPlsCmd == 8'd0);
        end
      end
      ST_RUN: begin
        if (pls_q) begin
          if (phase_end) begin
            cur_pos_d   = pos_step;
            remaining_d = remaining_dec;
            pls_d       = 1'b0;
            div_d       = half_period;
            if (stop_req) begin
              state_d = ST_IDLE;
              div_d   = 9'd0;
            end else if (!cont_q && remaining_q == 8'd1) begin
              state_d     = ST_IDLE;
              move_done_d = 1'b1;
              div_d       = 9'd0;
            end
          end else begin
            div_d = div_q - 9'd1;
            if (stop_req) state_d = ST_STOP;
          end
        end else begin
          if (stop_req) begin
            state_d = ST_IDLE;
            div_d   = 9'd0;
          end else if (phase_end) begin
            pls_d = 1'b1;
            div_d = half_period;
          end else begin
            div_d = div_q - 9'd1;
          end
        end
      end
      ST_STOP: begin
        if (phase_end) begin
          cur_pos_d   = pos_step;
          remaining_d = remaining_dec;
          pls_d       = 1'b0;
          div_d       = 9'd0;
          state_d     = ST_IDLE;
        end else begin
          div_d = div_q - 9'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pls_d   = 1'b0;
        div_d   = 9'd0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q      <= ST_IDLE;
      pls_q        <= 1'b0;
      dir_q        <= 1'b0;
      move_done_q  <= 1'b0;
      speed_done_q <= 1'b0;
      cur_pos_q    <= 16'h0000;
      speed_reg_q  <= 8'h00;
      remaining_q  <= 8'h00;
      cont_q       <= 1'b0;
      en_prev_q    <= 1'b0;
      en_armed_q   <= 1'b0;
      div_q        <= 9'd0;
    end else begin
      state_q      <= state_d;
      pls_q        <= pls_d;
      dir_q        <= dir_d;
      move_done_q  <= move_done_d;
      speed_done_q <= speed_done_d;
      cur_pos_q    <= cur_pos_d;
      speed_reg_q  <= speed_reg_d;
      remaining_q  <= remaining_d;
      cont_q       <= cont_d;
      en_prev_q    <= en_prev_d;
      en_armed_q   <= en_armed_d;
      div_q        <= div_d;
    end
  end

  assign SpeedSetDone = speed_done_q;
  assign Pls          = pls_q;
  assign Dir          = dir_q;
  assign Busy         = (state_q != ST_IDLE);
  assign MoveDone     = move_done_q;
  assign CurPos       = cur_pos_q;

endmodule

// File: tb/tb_axis_pulse_gen.sv
// Directed bench for axis_pulse_gen: stimulus pushes expected events into
// queues, a negedge monitor pops and compares them as the DUT produces them.
module tb_axis_pulse_gen;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        SpeedSet = 1'b0;
  logic [7:0]  SpeedCmd = 8'h00;
  logic [7:0]  AxisPlsCmd = 8'h00;
  logic [15:0] AxisStateCmd = 16'h0000;
  logic [15:0] RefPos = 16'h0000;
  logic        SpeedSetDone, Pls, Dir, Busy, MoveDone;
  logic [15:0] CurPos;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int hi;
    int pos;
  } fall_t;

  int    ack_q[$];
  int    rise_q[$];
  fall_t fall_q[$];
  int    done_q[$];

  axis_pulse_gen dut (
    .Clk(Clk), .Rst_n(Rst_n), .SpeedSet(SpeedSet), .SpeedCmd(SpeedCmd),
    .AxisPlsCmd(AxisPlsCmd), .AxisStateCmd(AxisStateCmd), .RefPos(RefPos),
    .SpeedSetDone(SpeedSetDone), .Pls(Pls), .Dir(Dir), .Busy(Busy),
    .MoveDone(MoveDone), .CurPos(CurPos)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event seen with nothing expected", name);
  endtask

  function automatic fall_t mk_fall(input int hi, input int pos);
    fall_t f;
    f.hi  = hi;
    f.pos = pos;
    return f;
  endfunction

  // Monitor: measures phase lengths and reports each output event.
  logic pls_prev = 1'b0;
  int   lo_cnt = 0;
  int   hi_cnt = 0;
  initial begin
    forever begin
      @(negedge Clk);
      if (Pls && !pls_prev) begin
        $display("t=%0t rise lo=%0d", $time, lo_cnt);
        if (rise_q.size() == 0) unexpected("rise");
        else check("rise_low_len", lo_cnt, rise_q.pop_front());
        hi_cnt = 0;
      end
      if (!Pls && pls_prev) begin
        fall_t f;
        $display("t=%0t fall hi=%0d pos=%04h", $time, hi_cnt, CurPos);
        if (fall_q.size() == 0) unexpected("fall");
        else begin
          f = fall_q.pop_front();
          check("fall_high_len", hi_cnt, f.hi);
          check("fall_pos", 32'(CurPos), f.pos);
        end
        lo_cnt = 0;
      end
      if (Pls) hi_cnt++;
      else if (Busy) lo_cnt++;
      else lo_cnt = 0;
      if (MoveDone) begin
        $display("t=%0t move_done pos=%04h busy=%0b", $time, CurPos, Busy);
        if (done_q.size() == 0) unexpected("move_done");
        else begin
          check("done_pos", 32'(CurPos), done_q.pop_front());
          check("done_busy", 32'(Busy), 0);
        end
      end
      if (SpeedSetDone) begin
        $display("t=%0t speed_ack", $time);
        if (ack_q.size() == 0) unexpected("speed_ack");
        else check("ack_time", int'($time), ack_q.pop_front());
      end
      pls_prev = Pls;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic set_speed(input logic [7:0] cmd);
    SpeedSet = 1'b1;
    SpeedCmd = cmd;
    ack_q.push_back(int'($time) + 10);
    @(negedge Clk);
    SpeedSet = 1'b0;
    @(negedge Clk);
  endtask

  task automatic wait_idle(input int limit, output int cyc);
    cyc = 0;
    do begin
      @(negedge Clk);
      cyc++;
    end while (Busy && cyc < limit);
    if (Busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: Busy still 1 after %0d cycles, required 0", cyc);
    end
  endtask

  initial begin
    int cyc;
    int ack_pat[3];
    ack_pat[0] = 1; ack_pat[1] = 0; ack_pat[2] = 1;

    // Reset state
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    check("rst_pls", 32'(Pls), 0);
    check("rst_busy", 32'(Busy), 0);
    check("rst_dir", 32'(Dir), 0);
    check("rst_done", 32'(MoveDone), 0);
    check("rst_ack", 32'(SpeedSetDone), 0);
    check("rst_pos", 32'(CurPos), 0);

    // Speed handshake held high for 3 cycles: ack 1,0,1
    SpeedSet = 1'b1;
    SpeedCmd = 8'hFE;
    ack_q.push_back(int'($time) + 10);
    ack_q.push_back(int'($time) + 30);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("ack_pattern", 32'(SpeedSetDone), ack_pat[i]);
    end
    SpeedSet = 1'b0;
    @(negedge Clk);

    // Counted move of 3 pulses, H=2, forward
    AxisPlsCmd = 8'd3;
    for (int i = 1; i <= 3; i++) begin
      rise_q.push_back(2);
      fall_q.push_back(mk_fall(2, i));
    end
    done_q.push_back(3);
    AxisStateCmd = 16'h0001;
    wait_idle(100, cyc);
    check("t2_busy_len", cyc - 1, 12);
    check("t2_pos", 32'(CurPos), 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check("t2_no_restart", 32'(Busy), 0);
    end
    AxisStateCmd = 16'h0000;
    @(negedge Clk);

    // Position preload then reverse 3-pulse move
    AxisStateCmd = 16'h0008;
    RefPos = 16'h0001;
    @(negedge Clk);
    check("t3_preload", 32'(CurPos), 1);
    AxisStateCmd = 16'h0003;
    fall_q.push_back(mk_fall(2, 32'h0000));
    fall_q.push_back(mk_fall(2, 32'hFFFF));
    fall_q.push_back(mk_fall(2, 32'hFFFE));
    for (int i = 0; i < 3; i++) rise_q.push_back(2);
    done_q.push_back(32'hFFFE);
    @(negedge Clk);
    check("t3_dir", 32'(Dir), 1);
    check("t3_busy", 32'(Busy), 1);
    wait_idle(100, cyc);
    check("t3_busy_len", cyc, 12);
    check("t3_pos", 32'(CurPos), 32'hFFFE);
    AxisStateCmd = 16'h0000;
    @(negedge Clk);

    // Continuous move H=4, abort in the second cycle of the second high phase
    set_speed(8'hFC);
    AxisPlsCmd = 8'd0;
    rise_q.push_back(4);
    fall_q.push_back(mk_fall(4, 32'hFFFF));
    rise_q.push_back(4);
    fall_q.push_back(mk_fall(4, 32'h0000));
    AxisStateCmd = 16'h0001;
    repeat (14) @(negedge Clk);
    check("t4_pls_before_abort", 32'(Pls), 1);
    AxisStateCmd = 16'h0005;
    @(negedge Clk);
    check("t4_stop_pls1", 32'(Pls), 1);
    check("t4_stop_busy", 32'(Busy), 1);
    @(negedge Clk);
    check("t4_stop_pls2", 32'(Pls), 1);
    @(negedge Clk);
    check("t4_end_pls", 32'(Pls), 0);
    check("t4_end_busy", 32'(Busy), 0);
    check("t4_end_pos", 32'(CurPos), 0);
    AxisStateCmd = 16'h0000;
    @(negedge Clk);

    // Continuous move H=2, speed change to H=4 mid-phase, disable in low phase
    set_speed(8'hFE);
    rise_q.push_back(2);
    fall_q.push_back(mk_fall(4, 1));
    rise_q.push_back(4);
    fall_q.push_back(mk_fall(4, 2));
    AxisStateCmd = 16'h0001;
    @(negedge Clk);
    SpeedSet = 1'b1;
    SpeedCmd = 8'hFC;
    ack_q.push_back(int'($time) + 10);
    @(negedge Clk);
    SpeedSet = 1'b0;
    repeat (14) @(negedge Clk);
    check("t5_pls_low", 32'(Pls), 0);
    AxisStateCmd = 16'h0000;
    @(negedge Clk);
    check("t5_busy", 32'(Busy), 0);
    check("t5_pos", 32'(CurPos), 2);
    check("t5_pls", 32'(Pls), 0);

    // Start with preload and same-cycle speed accept; reset mid-high phase
    AxisStateCmd = 16'h0009;
    RefPos = 16'h0005;
    SpeedSet = 1'b1;
    SpeedCmd = 8'hFE;
    ack_q.push_back(int'($time) + 10);
    rise_q.push_back(2);
    fall_q.push_back(mk_fall(1, 0));
    @(negedge Clk);
    SpeedSet = 1'b0;
    AxisStateCmd = 16'h0001;
    check("t6_busy", 32'(Busy), 1);
    check("t6_preload", 32'(CurPos), 5);
    @(negedge Clk);
    @(negedge Clk);
    check("t6_pls_high", 32'(Pls), 1);
    Rst_n = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    check("t6_rst_pls", 32'(Pls), 0);
    check("t6_rst_busy", 32'(Busy), 0);
    check("t6_rst_pos", 32'(CurPos), 0);
    check("t6_rst_done", 32'(MoveDone), 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      check("t6_no_restart", 32'(Busy), 0);
    end
    AxisStateCmd = 16'h0000;
    @(negedge Clk);
    @(negedge Clk);

    check("pending_events", ack_q.size() + rise_q.size() + fall_q.size() + done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
